adat_frame_fetcher: RTL and testbench
=====================================

ADAT_FRAME_FETCHER -- requirements
Module: adat_frame_fetcher

Interface
REQ-001 Parameter: CIRC_BUF_BITS, default 3, log2 of frame slots in channel_buffer.
REQ-002 Parameter: FRAME_ADDR_BITS, default 8, log2 of bits per frame (256). CIRC_BUF_BITS+FRAME_ADDR_BITS SHALL equal 11.
REQ-003 Port: clk_i  in  1  single clock, shared with i2s_msb_receiver and channel_buffer.
REQ-004 Port: rst_ni  in  1  reset, synchronous, active-low.
REQ-005 Port: last_good_frame_idx_i  in  CIRC_BUF_BITS  index of the newest complete frame from the receiver.
REQ-006 Port: frame_req_i  in  1  one-cycle pulse; the consumer requests the next frame.
REQ-007 Port: ram_read_addr_o  out  11  channel_buffer read address, {frame_idx, bit_idx}.
REQ-008 Port: ram_read_data_i  in  1  channel_buffer read data, valid one cycle after the address.
REQ-009 Port: word_o  out  32  channel word, MSB = first bit in the frame.
REQ-010 Port: word_valid_o  out  1  word_o holds a valid word.
REQ-011 Port: word_ready_i  in  1  the consumer accepts word_o.
REQ-012 Port: channel_idx_o  out  3  channel of word_o (0..7).
REQ-013 Port: frame_last_o  out  1  high with the channel-7 word.
REQ-014 Port: busy_o  out  1  high in every state other than IDLE.
REQ-015 Port: underrun_o, overrun_o  out  1 each  one-cycle status pulses.

Function
REQ-016 The block SHALL keep rd_idx, the next frame slot to read; avail = (last_good_frame_idx_i + 1 - rd_idx) mod 2^CIRC_BUF_BITS.
REQ-017 Until the first change of last_good_frame_idx_i after reset (synced=0), the block SHALL treat avail as 0; on that change it SHALL set rd_idx to the new last_good_frame_idx_i and set synced=1.
REQ-018 FSM states SHALL be IDLE, FETCH and PRESENT.
REQ-019 IDLE with frame_req_i=1 and avail=0: the block SHALL pulse underrun_o for 1 cycle and stay in IDLE.
REQ-020 IDLE with frame_req_i=1 and avail >= 2^CIRC_BUF_BITS-1: the block SHALL pulse overrun_o, set rd_idx to last_good_frame_idx_i, set ch=0, and enter FETCH.
REQ-021 IDLE with frame_req_i=1 and any other avail: the block SHALL set ch=0 and enter FETCH.
REQ-022 frame_req_i outside IDLE SHALL be ignored, with no status pulse.
REQ-023 FETCH SHALL issue 32 consecutive addresses {rd_idx, ch*32 + k}, k=0..31, one per cycle.
REQ-024 FETCH SHALL shift ram_read_data_i into word_o MSB-first, one cycle behind the address.
REQ-025 The block SHALL enter PRESENT, with word_valid_o=1, exactly 33 cycles after FETCH entry.
REQ-026 PRESENT: word_o, channel_idx_o and frame_last_o SHALL hold stable while word_valid_o=1 and word_ready_i=0.
REQ-027 A transfer occurs on a cycle with word_valid_o=1 and word_ready_i=1; word_valid_o SHALL drop on the next cycle.
REQ-028 A transfer with ch<7 SHALL increment ch and return to FETCH.
REQ-029 A transfer with ch=7 SHALL increment rd_idx modulo 2^CIRC_BUF_BITS and return to IDLE.
REQ-030 frame_last_o SHALL equal (ch==7) && word_valid_o.
REQ-031 ram_read_addr_o SHALL hold its last value outside FETCH.
REQ-032 Changes of last_good_frame_idx_i during FETCH or PRESENT SHALL affect only avail and never the frame in progress.
REQ-033 rd_idx wrap from 2^CIRC_BUF_BITS-1 to 0 SHALL be seamless, with no status pulse.

Reset
REQ-034 While rst_ni=0 at a clk_i edge, the block SHALL enter IDLE with rd_idx=0, ch=0, synced=0, and all outputs 0, including ram_read_addr_o.
REQ-035 Reset asserted mid-FETCH or mid-PRESENT SHALL abort the frame; the next frame SHALL start only after a resync per REQ-017.

Structure
REQ-036 A shared package (adat_pkg) SHALL hold: FSM state enum, CHANNELS=8, WORD_BITS=32, RAM_ADDR_BITS=11.
REQ-037 One sub-module, frame_word_shifter (32-bit MSB-first shift register with load-enable), SHALL be used; the rest is a flat FSM.

Verification
REQ-038 Reset, then last_good 0->2, then frame_req: the bench SHALL see rd_idx=2, addresses 0x200..0x2FF in order, 8 words matching the RAM, and frame_last_o on ch 7.
REQ-039 frame_req right after reset with no last_good change: the bench SHALL see underrun_o pulse once and busy_o=0.
REQ-040 word_ready_i held low 10 cycles in PRESENT: the bench SHALL see word_o, channel_idx_o and word_valid_o stable; one transfer then follows.
REQ-041 rd_idx=3, last_good advanced to 1 (avail=7), then frame_req: the bench SHALL see overrun_o pulse and fetch from slot 1 (address 0x100).
REQ-042 Read at rd_idx=7, then a second frame: the bench SHALL see the second fetch start at address 0x000 with no status pulse.
REQ-043 rst_ni low at cycle 10 of FETCH: the bench SHALL see all outputs 0 on the next cycle, and underrun_o on a subsequent frame_req before resync.

Source files
------------

// File: rtl/adat_pkg.sv
`default_nettype none
// ============================================================================
// Module : adat_pkg
// Brief  : Shared FSM state type and sizing constants for the ADAT fetch path.
// Rev    : 1.0 - initial release
// ============================================================================
package adat_pkg;

  localparam int CHANNELS      = 8;
  localparam int WORD_BITS     = 32;
  localparam int RAM_ADDR_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_word_shifter.sv
`default_nettype none
// ============================================================================
// Module : frame_word_shifter
// Brief  : MSB-first serial-to-parallel shift register with shift enable.
// Rev    : 1.0 - initial release
// ============================================================================
module frame_word_shifter
  import adat_pkg::*;
#(
  parameter int WIDTH = WORD_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] r_word;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_word <= '0;
    end else if (shift_en_i) begin
      r_word <= {r_word[WIDTH-2:0], bit_i};
    end
  end

  assign word_o = r_word;

endmodule
`default_nettype wire

// File: rtl/adat_frame_fetcher.sv
`default_nettype none
// ============================================================================
// Module : adat_frame_fetcher
// Brief  : Reads one frame of 8 x 32-bit channel words out of the circular
//          channel buffer and presents them on a valid/ready word port.
// Rev    : 1.0 - initial release
// ============================================================================
module adat_frame_fetcher
  import adat_pkg::*;
#(
  parameter int CIRC_BUF_BITS   = 3,
  parameter int FRAME_ADDR_BITS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
  input  logic                     frame_req_i,
  output logic [RAM_ADDR_BITS-1:0] ram_read_addr_o,
  input  logic                     ram_read_data_i,
  output logic [WORD_BITS-1:0]     word_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i,
  output logic [2:0]               channel_idx_o,
  output logic                     frame_last_o,
  output logic                     busy_o,
  output logic                     underrun_o,
  output logic                     overrun_o
);

  localparam int               c_bit_w         = $clog2(WORD_BITS);
  localparam logic [c_bit_w:0] c_cnt_last_addr = (c_bit_w + 1)'(WORD_BITS - 1);
  localparam logic [c_bit_w:0] c_cnt_done      = (c_bit_w + 1)'(WORD_BITS);
  localparam logic [2:0]       c_last_ch       = 3'(CHANNELS - 1);

  fetch_state_t               r_state;
  logic [CIRC_BUF_BITS-1:0]   r_rd_idx;
  logic [CIRC_BUF_BITS-1:0]   r_last_good_q;
  logic                       r_synced;
  logic [2:0]                 r_ch;
  logic [c_bit_w:0]           r_cnt;
  logic [RAM_ADDR_BITS-1:0]   r_addr;
  logic                       r_valid;
  logic                       r_underrun;
  logic                       r_overrun;

  logic [CIRC_BUF_BITS-1:0]   w_avail;
  logic                       w_full;
  logic [2:0]                 w_ch_next;
  logic                       w_shift_en;

  function automatic logic [RAM_ADDR_BITS-1:0] frame_addr(
    input logic [CIRC_BUF_BITS-1:0] slot,
    input logic [2:0]               ch,
    input logic [c_bit_w-1:0]       bit_idx
  );
    frame_addr = {slot, FRAME_ADDR_BITS'({ch, bit_idx})};
  endfunction

  // An unsynced buffer position is meaningless, so it reads as empty.
  assign w_avail    = r_synced ? (last_good_frame_idx_i + CIRC_BUF_BITS'(1) - r_rd_idx) : '0;
  assign w_full     = &w_avail;
  assign w_ch_next  = r_ch + 3'd1;
  // Read data lags the address by one cycle, so the first FETCH cycle has nothing to capture.
  assign w_shift_en = (r_state == ST_FETCH) && (r_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_rd_idx      <= '0;
      r_last_good_q <= last_good_frame_idx_i;
      r_synced      <= 1'b0;
      r_ch          <= '0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_valid       <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
      r_last_good_q <= last_good_frame_idx_i;

      if (!r_synced && (last_good_frame_idx_i != r_last_good_q)) begin
        r_synced <= 1'b1;
        r_rd_idx <= last_good_frame_idx_i;
      end

      case (r_state)
        ST_IDLE: begin
          if (frame_req_i) begin
            if (w_avail == '0) begin
              r_underrun <= 1'b1;
            end else begin
              r_ch    <= '0;
              r_cnt   <= '0;
              r_state <= ST_FETCH;
              if (w_full) begin
                r_overrun <= 1'b1;
                r_rd_idx  <= last_good_frame_idx_i;
                r_addr    <= frame_addr(last_good_frame_idx_i, 3'd0, '0);
              end else begin
                r_addr    <= frame_addr(r_rd_idx, 3'd0, '0);
              end
            end
          end
        end

        ST_FETCH: begin
          if (r_cnt < c_cnt_last_addr) begin
            r_addr <= r_addr + RAM_ADDR_BITS'(1);
          end
          if (r_cnt == c_cnt_done) begin
            r_state <= ST_PRESENT;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + (c_bit_w + 1)'(1);
          end
        end

        ST_PRESENT: begin
          if (word_ready_i) begin
            r_valid <= 1'b0;
            if (r_ch == c_last_ch) begin
              r_rd_idx <= r_rd_idx + CIRC_BUF_BITS'(1);
              r_state  <= ST_IDLE;
            end else begin
              r_ch    <= w_ch_next;
              r_cnt   <= '0;
              r_addr  <= frame_addr(r_rd_idx, w_ch_next, '0);
              r_state <= ST_FETCH;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  frame_word_shifter #(
    .WIDTH (WORD_BITS)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .shift_en_i (w_shift_en),
    .bit_i      (ram_read_data_i),
    .word_o     (word_o)
  );

  assign ram_read_addr_o = r_addr;
  assign word_valid_o    = r_valid;
  assign channel_idx_o   = r_ch;
  assign frame_last_o    = (r_ch == c_last_ch) && r_valid;
  assign busy_o          = (r_state != ST_IDLE);
  assign underrun_o      = r_underrun;
  assign overrun_o       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adat_frame_fetcher.sv
`default_nettype none
// ============================================================================
// Module : tb_adat_frame_fetcher
// Brief  : Self-checking bench: directed sequences, an outcome table and
//          randomized traffic against a slot/avail reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_adat_frame_fetcher;

  localparam int SLOTS = 8;

  logic        clk;
  logic        rst_n;
  logic [2:0]  last_good;
  logic        frame_req;
  logic [10:0] ram_read_addr;
  logic        ram_read_data;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  channel_idx;
  logic        frame_last;
  logic        busy;
  logic        underrun;
  logic        overrun;

  bit ram [0:2047];

  int n_cmp;
  int n_fail;
  int cnt_under;
  int cnt_over;

  int m_rd;
  int m_lg;
  bit m_synced;

  typedef struct {
    int s;
    int l;
    bit e_u;
    bit e_o;
    int slot;
  } vec_t;

  vec_t tbl [7];

  adat_frame_fetcher #(
    .CIRC_BUF_BITS   (3),
    .FRAME_ADDR_BITS (8)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .last_good_frame_idx_i (last_good),
    .frame_req_i           (frame_req),
    .ram_read_addr_o       (ram_read_addr),
    .ram_read_data_i       (ram_read_data),
    .word_o                (word),
    .word_valid_o          (word_valid),
    .word_ready_i          (word_ready),
    .channel_idx_o         (channel_idx),
    .frame_last_o          (frame_last),
    .busy_o                (busy),
    .underrun_o            (underrun),
    .overrun_o             (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel buffer: registered single-bit read port.
  always @(posedge clk) ram_read_data <= ram[ram_read_addr];

  always @(posedge clk) begin
    if (underrun) cnt_under <= cnt_under + 1;
    if (overrun)  cnt_over  <= cnt_over + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int slot, input int ch);
    logic [31:0] w;
    for (int k = 0; k < 32; k++) w[31-k] = ram[slot*256 + ch*32 + k];
    return w;
  endfunction

  task automatic set_lg_now(input int v);
    if (!m_synced && v != m_lg) begin
      m_synced = 1'b1;
      m_rd     = v;
    end
    m_lg      = v;
    last_good = 3'(v);
  endtask

  task automatic set_lg(input int v);
    set_lg_now(v);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(ram_read_addr), 0);
    chk({tag, "_word"},  word, 0);
    chk({tag, "_valid"}, 32'(word_valid), 0);
    chk({tag, "_chan"},  32'(channel_idx), 0);
    chk({tag, "_last"},  32'(frame_last), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_pulse"}, 32'({underrun, overrun}), 0);
  endtask

  task automatic do_reset(input int lg);
    rst_n      = 1'b0;
    frame_req  = 1'b0;
    word_ready = 1'b0;
    last_good  = 3'(lg);
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    m_lg     = lg;
    m_synced = 1'b0;
    m_rd     = 0;
    @(negedge clk);
  endtask

  // Reference outcome of a frame request from the avail rules.
  task automatic predict(output bit u, output bit o, output int slot);
    int avail;
    avail = m_synced ? ((m_lg + 1 - m_rd + SLOTS) % SLOTS) : 0;
    u     = (avail == 0);
    o     = (avail == SLOTS - 1);
    slot  = o ? m_lg : m_rd;
  endtask

  task automatic run_frame(input int slot, input int stall_ch, input bit noise);
    for (int ch = 0; ch < 8; ch++) begin
      int          cyc;
      int          stall;
      logic [31:0] w_exp;
      cyc   = 0;
      w_exp = exp_word(slot, ch);
      for (int k = 0; k < 32; k++) begin
        chk("fetch_addr", 32'(ram_read_addr), 32'(slot*256 + ch*32 + k));
        if (noise) begin
          frame_req = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 15) == 0) set_lg_now(int'($urandom_range(0, 7)));
        end
        @(negedge clk);
        cyc++;
      end
      while (!word_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      chk("present_latency", 32'(cyc), 33);
      chk("word", word, w_exp);
      chk("channel_idx", 32'(channel_idx), 32'(ch));
      chk("frame_last", 32'(frame_last), 32'(ch == 7));
      stall = (ch == stall_ch) ? 10 : (noise ? int'($urandom_range(0, 3)) : 0);
      if (stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          if (noise) frame_req = $urandom_range(0, 1);
          @(negedge clk);
        end
        chk("stall_valid", 32'(word_valid), 1);
        chk("stall_word", word, w_exp);
        chk("stall_channel", 32'(channel_idx), 32'(ch));
        chk("stall_last", 32'(frame_last), 32'(ch == 7));
      end
      frame_req  = 1'b0;
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      chk("valid_drop", 32'(word_valid), 0);
      if (ch == 7) chk("busy_end", 32'(busy), 0);
    end
  endtask

  task automatic request(input bit e_u, input bit e_o, input int e_slot,
                         input int stall_ch, input bit noise);
    int u0;
    int o0;
    u0 = cnt_under;
    o0 = cnt_over;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    chk("underrun_pulse", 32'(underrun), 32'(e_u));
    chk("overrun_pulse", 32'(overrun), 32'(e_o));
    chk("busy_after_req", 32'(busy), 32'(!e_u));
    if (e_u) begin
      @(negedge clk);
      chk("busy_idle", 32'(busy), 0);
    end else begin
      run_frame(e_slot, stall_ch, noise);
      m_rd = (e_slot + 1) % SLOTS;
    end
    chk("underrun_count", 32'(cnt_under - u0), 32'(e_u));
    chk("overrun_count", 32'(cnt_over - o0), 32'(e_o));
  endtask

  initial begin
    bit u;
    bit o;
    int sl;

    n_cmp      = 0;
    n_fail     = 0;
    cnt_under  = 0;
    cnt_over   = 0;
    rst_n      = 1'b0;
    frame_req  = 1'b0;
    word_ready = 1'b0;
    last_good  = 3'd0;
    for (int i = 0; i < 2048; i++) ram[i] = bit'($urandom_range(0, 1));

    tbl[0] = '{2, 2, 1'b0, 1'b0, 2};
    tbl[1] = '{2, 5, 1'b0, 1'b0, 2};
    tbl[2] = '{2, 1, 1'b1, 1'b0, 0};
    tbl[3] = '{5, 3, 1'b0, 1'b1, 3};
    tbl[4] = '{7, 7, 1'b0, 1'b0, 7};
    tbl[5] = '{0, 6, 1'b0, 1'b1, 6};
    tbl[6] = '{0, 5, 1'b0, 1'b0, 0};

    @(negedge clk);
    do_reset(0);

    // Request before any resync: underrun, stays idle.
    request(1'b1, 1'b0, 0, -1, 1'b0);

    // Resync to slot 2, read the frame with a 10-cycle stall on channel 3.
    set_lg(2);
    request(1'b0, 1'b0, 2, 3, 1'b0);

    // rd_idx now 3; last_good 1 gives avail 7 -> overrun, fetch from slot 1.
    set_lg(1);
    request(1'b0, 1'b1, 1, -1, 1'b0);

    // Frame at slot 7 followed by a seamless wrap to slot 0.
    do_reset(0);
    set_lg(7);
    set_lg(0);
    request(1'b0, 1'b0, 7, -1, 1'b0);
    request(1'b0, 1'b0, 0, -1, 1'b0);

    // Reset at cycle 10 of FETCH aborts the frame; no resync -> underrun.
    do_reset(0);
    set_lg(4);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    rst_n    = 1'b1;
    m_synced = 1'b0;
    m_rd     = 0;
    @(negedge clk);
    request(1'b1, 1'b0, 0, -1, 1'b0);

    for (int t = 0; t < 7; t++) begin
      do_reset((tbl[t].s + 4) % SLOTS);
      set_lg(tbl[t].s);
      set_lg(tbl[t].l);
      request(tbl[t].e_u, tbl[t].e_o, tbl[t].slot, -1, 1'b0);
    end

    for (int it = 0; it < 30; it++) begin
      int act;
      act = int'($urandom_range(0, 9));
      if (act == 0) begin
        do_reset(int'($urandom_range(0, 7)));
      end else if (act <= 2) begin
        set_lg(int'($urandom_range(0, 7)));
      end else if (act == 3) begin
        set_lg((m_lg + 1) % SLOTS);
      end else begin
        predict(u, o, sl);
        request(u, o, sl, -1, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
